// File: rtl/cache_axi_rd_arbiter_pkg.sv
// Shared types and constants for the cache-side AXI read arbiter.
// Requester indices double as the AXI arid value.
package cache_axi_rd_arbiter_pkg;

    typedef logic [31:0]  bus32_t;
    typedef logic [255:0] bus256_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } axi_rd_state_t;

    localparam logic [1:0] REQ_IC = 2'd0;
    localparam logic [1:0] REQ_IU = 2'd1;
    localparam logic [1:0] REQ_DC = 2'd2;
    localparam logic [1:0] REQ_DU = 2'd3;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

    // Line refills are bursts; the uncached paths are single beats.
    function automatic logic is_line_req(input logic [1:0] idx);
        return (idx == REQ_IC) || (idx == REQ_DC);
    endfunction

endpackage

// File: rtl/cache_axi_rd_arbiter_rr.sv
// Four-way round-robin arbiter: the search starts at ptr_i and wraps.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter4 (
    input  logic [3:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [3:0] grant_o,
    output logic [1:0] idx_o
);

    logic       found;
    logic [1:0] cand;

    always_comb begin
        found = 1'b0;
        cand  = ptr_i;
        idx_o = ptr_i;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_i + 2'(k);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                idx_o = cand;
            end
        end
        grant_o = found ? (4'b0001 << idx_o) : 4'b0000;
    end

endmodule

// File: rtl/cache_axi_rd_arbiter.sv
// Shares one AXI4 read channel among icache/dcache refill and uncached reads,
// one outstanding transaction at a time, with a one-cycle done pulse to the owner.
module cache_axi_rd_arbiter
    import cache_axi_rd_arbiter_pkg::*;
#(
    parameter int LINE_BEATS = 8,
    parameter int ID_W       = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ic_rd_req,
    input  logic [31:0]     ic_rd_addr,
    output logic            ic_ret_valid,
    output logic [255:0]    ic_ret_data,
    input  logic            iu_ren,
    input  logic [31:0]     iu_addr,
    output logic            iu_rvalid,
    output logic [31:0]     iu_rdata,
    input  logic            dc_rd_req,
    input  logic [31:0]     dc_rd_addr,
    output logic            dc_ret_valid,
    output logic [255:0]    dc_ret_data,
    input  logic            du_ren,
    input  logic [31:0]     du_addr,
    output logic            du_rvalid,
    output logic [31:0]     du_rdata,
    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic            arvalid,
    input  logic            arready,
    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready
);

    axi_rd_state_t state_q;
    logic [1:0]    ptr_q;
    logic [1:0]    owner_q;
    bus32_t        araddr_q;
    logic [7:0]    arlen_q;
    logic          arvalid_q;
    logic          rready_q;
    logic [2:0]    beat_q;
    bus256_t       ic_data_q;
    bus256_t       dc_data_q;
    bus32_t        iu_data_q;
    bus32_t        du_data_q;
    logic [3:0]    ret_q;

    logic [3:0]    req_vec;
    logic [3:0]    gnt_onehot;
    logic [1:0]    gnt_idx;
    bus32_t        araddr_d;
    logic [7:0]    arlen_d;

    assign req_vec = {du_ren, dc_rd_req, iu_ren, ic_rd_req};

    rr_arbiter4 u_rr (
        .req_i   (req_vec),
        .ptr_i   (ptr_q),
        .grant_o (gnt_onehot),
        .idx_o   (gnt_idx)
    );

    // Refills are line aligned; uncached addresses pass through untouched.
    always_comb begin
        araddr_d = iu_addr;
        case (gnt_idx)
            REQ_IC:  araddr_d = {ic_rd_addr[31:5], 5'b0};
            REQ_IU:  araddr_d = iu_addr;
            REQ_DC:  araddr_d = {dc_rd_addr[31:5], 5'b0};
            default: araddr_d = du_addr;
        endcase
        arlen_d = is_line_req(gnt_idx) ? 8'(LINE_BEATS - 1) : 8'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            owner_q   <= 2'd0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            beat_q    <= 3'd0;
            ic_data_q <= '0;
            dc_data_q <= '0;
            iu_data_q <= '0;
            du_data_q <= '0;
            ret_q     <= 4'b0;
        end else begin
            ret_q <= 4'b0;
            case (state_q)
                IDLE: begin
                    if (|req_vec) begin
                        owner_q   <= gnt_idx;
                        ptr_q     <= gnt_idx + 2'd1;
                        araddr_q  <= araddr_d;
                        arlen_q   <= arlen_d;
                        arvalid_q <= 1'b1;
                        beat_q    <= 3'd0;
                        state_q   <= ADDR;
                    end
                end
                ADDR: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (rvalid) begin
                        beat_q <= beat_q + 3'd1;
                        case (owner_q)
                            REQ_IC:  ic_data_q[{beat_q, 5'd0} +: 32] <= rdata;
                            REQ_IU:  iu_data_q <= rdata;
                            REQ_DC:  dc_data_q[{beat_q, 5'd0} +: 32] <= rdata;
                            default: du_data_q <= rdata;
                        endcase
                        // A short burst still finishes; untouched slots keep old data.
                        if (rlast) begin
                            rready_q       <= 1'b0;
                            ret_q[owner_q] <= 1'b1;
                            state_q        <= RESP;
                        end
                    end
                end
                RESP: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign arid    = {{(ID_W-2){1'b0}}, owner_q};
    assign araddr  = araddr_q;
    assign arlen   = arlen_q;
    assign arsize  = AXI_SIZE_4B;
    assign arburst = AXI_BURST_INCR;
    assign arvalid = arvalid_q;
    assign rready  = rready_q;

    assign ic_ret_valid = ret_q[REQ_IC];
    assign iu_rvalid    = ret_q[REQ_IU];
    assign dc_ret_valid = ret_q[REQ_DC];
    assign du_rvalid    = ret_q[REQ_DU];
    assign ic_ret_data  = ic_data_q;
    assign dc_ret_data  = dc_data_q;
    assign iu_rdata     = iu_data_q;
    assign du_rdata     = du_data_q;

    // rid/rresp are deliberately ignored: data is delivered whatever the response.
    logic unused_sigs;
    assign unused_sigs = ^{rid, rresp, gnt_onehot};

endmodule

// File: tb/tb_cache_axi_rd_arbiter.sv
// Directed bench for cache_axi_rd_arbiter: latency, address shaping, round-robin order,
// flush during AR stall, rvalid gaps and reset in the middle of a burst.
module tb_cache_axi_rd_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic         ic_rd_req, iu_ren, dc_rd_req, du_ren;
    logic [31:0]  ic_rd_addr, iu_addr, dc_rd_addr, du_addr;
    logic         ic_ret_valid, iu_rvalid, dc_ret_valid, du_rvalid;
    logic [255:0] ic_ret_data, dc_ret_data;
    logic [31:0]  iu_rdata, du_rdata;
    logic [3:0]   arid, rid;
    logic [31:0]  araddr, rdata;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst, rresp;
    logic         arvalid, arready, rlast, rvalid, rready;

    int checks = 0;
    int errors = 0;

    cache_axi_rd_arbiter #(.LINE_BEATS(8), .ID_W(4)) dut (
        .clk(clk), .reset(reset),
        .ic_rd_req(ic_rd_req), .ic_rd_addr(ic_rd_addr), .ic_ret_valid(ic_ret_valid), .ic_ret_data(ic_ret_data),
        .iu_ren(iu_ren), .iu_addr(iu_addr), .iu_rvalid(iu_rvalid), .iu_rdata(iu_rdata),
        .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr), .dc_ret_valid(dc_ret_valid), .dc_ret_data(dc_ret_data),
        .du_ren(du_ren), .du_addr(du_addr), .du_rvalid(du_rvalid), .du_rdata(du_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] pulses();
        return {du_rvalid, dc_ret_valid, iu_rvalid, ic_ret_valid};
    endfunction

    function automatic logic [255:0] line_of(input logic [31:0] base);
        logic [255:0] l;
        l = '0;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = base + 32'(k);
        return l;
    endfunction

    // Drives n beats of base+k; rlast on beat total-1. With gaps, an idle cycle precedes each later beat.
    task automatic burst(input int n, input logic [31:0] base, input bit gaps, input int total);
        for (int k = 0; k < n; k++) begin
            if (gaps && k > 0) begin
                rvalid = 1'b0;
                rdata  = 32'hDEAD_BEEF;
                rlast  = 1'b0;
                tick();
                chk("gap_no_pulse", pulses(), 4'b0000);
            end
            rvalid = 1'b1;
            rdata  = base + 32'(k);
            rlast  = (k == total - 1);
            tick();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rdata  = '0;
    endtask

    task automatic wait_ar();
        int n;
        n = 0;
        while (arvalid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("ar_wait", arvalid, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  ord [5];
        logic [31:0] ar_exp [4];
        ord = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        ar_exp = '{32'h0000_0100, 32'h0000_0204, 32'h0000_0300, 32'h0000_0404};

        reset = 1'b1;
        {ic_rd_req, iu_ren, dc_rd_req, du_ren} = 4'b0;
        ic_rd_addr = '0; iu_addr = '0; dc_rd_addr = '0; du_addr = '0;
        arready = 1'b0; rid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
        tick();
        tick();
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_rready", rready, 1'b0);
        chk("rst_pulses", pulses(), 4'b0000);
        chk("rst_ic_data", ic_ret_data, '0);
        chk("rst_du_data", du_rdata, '0);
        reset = 1'b0;

        // Line refill, all-ready latency
        ic_rd_req = 1'b1; ic_rd_addr = 32'h1C00_0014; arready = 1'b1;
        tick();
        chk("ic_arvalid_c1", arvalid, 1'b1);
        chk("ic_araddr", araddr, 32'h1C00_0000);
        chk("ic_arlen", arlen, 8'd7);
        chk("ic_arid", arid, 4'd0);
        chk("ic_arsize", arsize, 3'b010);
        chk("ic_arburst", arburst, 2'b01);
        ic_rd_req = 1'b0;
        tick();
        chk("ic_rready_c2", rready, 1'b1);
        chk("ic_arvalid_drop", arvalid, 1'b0);
        burst(8, 32'h0, 1'b0, 8);
        chk("ic_pulse_c10", pulses(), 4'b0001);
        chk("ic_data", ic_ret_data, line_of(32'h0));
        tick();
        chk("ic_pulse_one", pulses(), 4'b0000);
        chk("ic_data_hold", ic_ret_data, line_of(32'h0));

        // Uncached fetch
        iu_ren = 1'b1; iu_addr = 32'h1C00_0008;
        tick();
        chk("iu_arvalid", arvalid, 1'b1);
        chk("iu_araddr", araddr, 32'h1C00_0008);
        chk("iu_arlen", arlen, 8'd0);
        chk("iu_arid", arid, 4'd1);
        iu_ren = 1'b0;
        tick();
        burst(1, 32'h0280_0000, 1'b0, 1);
        chk("iu_pulse_c3", pulses(), 4'b0010);
        chk("iu_rdata", iu_rdata, 32'h0280_0000);
        tick();
        chk("iu_pulse_one", pulses(), 4'b0000);

        // Round-robin order with all four held from reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ic_rd_addr = 32'h0000_0110; iu_addr = ar_exp[1]; dc_rd_addr = 32'h0000_031F; du_addr = ar_exp[3];
        {du_ren, dc_rd_req, iu_ren, ic_rd_req} = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_ar();
            chk($sformatf("rr_arid_%0d", i), arid, 4'(ord[i]));
            chk($sformatf("rr_araddr_%0d", i), araddr, ar_exp[ord[i]]);
            tick();
            if (ord[i] == 2'd0 || ord[i] == 2'd2) burst(8, 32'h1000 * (i + 1), 1'b0, 8);
            else burst(1, 32'h1000 * (i + 1), 1'b0, 1);
            if (i == 4) {du_ren, dc_rd_req, iu_ren, ic_rd_req} = 4'b0000;
            chk($sformatf("rr_pulse_%0d", i), pulses(), 4'b0001 << ord[i]);
            tick();
        end
        chk("rr_du_rdata", du_rdata, 32'h4000);
        chk("rr_dc_data", dc_ret_data, line_of(32'h3000));

        // Flush while AR is stalled
        ic_rd_req = 1'b1; ic_rd_addr = 32'h1C00_0044; arready = 1'b0;
        tick();
        chk("fl_arvalid", arvalid, 1'b1);
        chk("fl_araddr", araddr, 32'h1C00_0040);
        ic_rd_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("fl_hold_arvalid_%0d", i), arvalid, 1'b1);
            chk($sformatf("fl_hold_araddr_%0d", i), araddr, 32'h1C00_0040);
        end
        arready = 1'b1;
        tick();
        chk("fl_rready", rready, 1'b1);
        burst(8, 32'h100, 1'b0, 8);
        chk("fl_pulse", pulses(), 4'b0001);
        chk("fl_data", ic_ret_data, line_of(32'h100));
        tick();

        // rvalid gaps across a dcache refill
        dc_rd_req = 1'b1; dc_rd_addr = 32'h3000_0074;
        tick();
        chk("gp_arid", arid, 4'd2);
        chk("gp_araddr", araddr, 32'h3000_0060);
        dc_rd_req = 1'b0;
        tick();
        burst(8, 32'hA0, 1'b1, 8);
        chk("gp_pulse", pulses(), 4'b0100);
        chk("gp_data", dc_ret_data, line_of(32'hA0));
        tick();
        chk("gp_pulse_one", pulses(), 4'b0000);

        // Reset in the middle of a burst, then a clean refill
        dc_rd_req = 1'b1; dc_rd_addr = 32'h2000_0040;
        tick();
        dc_rd_req = 1'b0;
        tick();
        burst(3, 32'h500, 1'b0, 8);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_arvalid", arvalid, 1'b0);
        chk("mr_rready", rready, 1'b0);
        chk("mr_pulses", pulses(), 4'b0000);
        chk("mr_dc_data", dc_ret_data, '0);
        dc_rd_req = 1'b1;
        tick();
        chk("mr_arvalid_new", arvalid, 1'b1);
        chk("mr_arid_new", arid, 4'd2);
        chk("mr_araddr_new", araddr, 32'h2000_0040);
        dc_rd_req = 1'b0;
        tick();
        burst(8, 32'h600, 1'b0, 8);
        chk("mr_pulse_new", pulses(), 4'b0100);
        chk("mr_data_new", dc_ret_data, line_of(32'h600));
        tick();
        chk("mr_idle", arvalid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
